// File: rtl/eth_pcs_params.sv
// ----------------------------------------------------------------------------
// eth_pcs_params
// Shared constants and types for the 10GBASE-R style PCS transmit path:
// datapath widths, scrambler polynomial taps and seed, PRBS31 taps and seed,
// and the transmit mode enumeration.
// ----------------------------------------------------------------------------
package eth_pcs_params;

   localparam int W_DATA          = 32;
   localparam int W_SYNC          = 2;
   localparam int W_TRANS_PER_BLK = 1;

   // Self-synchronous scrambler G(x) = 1 + x^39 + x^58
   localparam int W_SCR_STATE = 58;
   localparam int SCR_TAP_A   = 39;
   localparam int SCR_TAP_B   = 58;
   localparam logic [W_SCR_STATE-1:0] SCR_SEED = '1;

   // PRBS31: b[n] = b[n-31] ^ b[n-28]
   localparam int W_PRBS31     = 31;
   localparam int PRBS31_TAP_A = 31;
   localparam int PRBS31_TAP_B = 28;
   localparam logic [W_PRBS31-1:0] PRBS31_SEED = '1;

   typedef enum logic [1:0] {
      MODE_NORMAL   = 2'd0,
      MODE_BYPASS   = 2'd1,
      MODE_PRBS31   = 2'd2,
      MODE_RESERVED = 2'd3
   } mode_e;

   // Reserved encoding behaves exactly like normal operation.
   function automatic mode_e norm_mode(input logic [1:0] m);
      mode_e r;
      case (m)
         2'd1:    r = MODE_BYPASS;
         2'd2:    r = MODE_PRBS31;
         default: r = MODE_NORMAL;
      endcase
      return r;
   endfunction

   // Unrolls 32 PRBS31 steps. seq[30-k] = history bit generated k+1 bits
   // ago (p[k]); seq[31+i] = newly generated bit i of the current word.
   function automatic logic [W_PRBS31+W_DATA-1:0] prbs31_expand(
      input logic [W_PRBS31-1:0] p
   );
      logic [W_PRBS31+W_DATA-1:0] seq;
      seq = '0;
      for (int unsigned k = 0; k < W_PRBS31; k++)
         seq[W_PRBS31-1-k] = p[k];
      for (int unsigned i = 0; i < W_DATA; i++)
         seq[W_PRBS31+i] = seq[i] ^ seq[i + (PRBS31_TAP_A - PRBS31_TAP_B)];
      return seq;
   endfunction

endpackage

// File: rtl/eth_pcs_prbs31_gen.sv
// ----------------------------------------------------------------------------
// eth_pcs_prbs31_gen
// Word-parallel PRBS31 test-pattern generator, 32 bits per enabled cycle.
// word_o is combinational from the current state (zero latency); the state
// advances by one word on each clock with en_i high.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, loads PRBS31_SEED
//   en_i   : advance state by 32 bits
//   word_o : current 32-bit pattern word, bit 0 first
// ----------------------------------------------------------------------------
module eth_pcs_prbs31_gen
   import eth_pcs_params::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   output logic [W_DATA-1:0] word_o
);

   logic [W_PRBS31-1:0]        p_q, p_d;
   logic [W_PRBS31+W_DATA-1:0] seq;

   always_comb begin
      seq    = prbs31_expand(p_q);
      word_o = seq[W_PRBS31 +: W_DATA];
      p_d    = p_q;
      // New history: p[k] = bit generated k+1 bits before the next word.
      if (en_i) begin
         for (int unsigned k = 0; k < W_PRBS31; k++)
            p_d[k] = seq[W_PRBS31+W_DATA-1-k];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) p_q <= PRBS31_SEED;
      else       p_q <= p_d;
   end

endmodule

// File: rtl/eth_pcs_tx_scrambler.sv
// ----------------------------------------------------------------------------
// eth_pcs_tx_scrambler
// PCS transmit scrambler: 1 + x^39 + x^58 self-synchronous scrambler with
// bypass and PRBS31 test modes. Mode changes take effect at block
// boundaries only. Sync header passes through unscrambled.
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_clk_en         : transfer enable from the gearbox
//   i_trans_cnt      : transfer index within the 66b block (0 = first half)
//   i_mode           : 0 normal, 1 bypass, 2 PRBS31, 3 treated as normal
//   i_sync_data      : sync header in  -> o_sync_data (unchanged)
//   i_data           : payload half-block, bit 0 first -> o_scr_data
//   o_mode_active    : mode applied to the current output
// ----------------------------------------------------------------------------
module eth_pcs_tx_scrambler
   import eth_pcs_params::*;
(
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_clk_en,
   input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
   input  logic [1:0]                 i_mode,
   input  logic [W_SYNC-1:0]          i_sync_data,
   input  logic [W_DATA-1:0]          i_data,
   output logic [W_SYNC-1:0]          o_sync_data,
   output logic [W_DATA-1:0]          o_scr_data,
   output logic [1:0]                 o_mode_active
);

   mode_e                  mode_q, mode_d, mode_eff;
   logic [W_SCR_STATE-1:0] s_q, s_d;
   logic [W_DATA-1:0]      scr_w, scr_rev, prbs_w;
   logic                   prbs_en;

   // A new mode is sampled only at the first transfer of a block and
   // already governs that transfer's output.
   always_comb begin
      mode_eff = mode_q;
      if (i_clk_en && (i_trans_cnt == '0))
         mode_eff = norm_mode(i_mode);
      mode_d = i_clk_en ? mode_eff : mode_q;
   end

   // S[k] is the scrambled bit sent k+1 bits ago; since 32 < 39 no bit of
   // the current word feeds back into the same word.
   always_comb begin
      scr_w   = '0;
      scr_rev = '0;
      for (int unsigned i = 0; i < W_DATA; i++)
         scr_w[i] = i_data[i] ^ s_q[SCR_TAP_A-1-i] ^ s_q[SCR_TAP_B-1-i];
      for (int unsigned k = 0; k < W_DATA; k++)
         scr_rev[k] = scr_w[W_DATA-1-k];
   end

   // Bypass keeps advancing S so a return to normal stays in sync.
   always_comb begin
      s_d = s_q;
      if (i_clk_en && (mode_eff != MODE_PRBS31))
         s_d = {s_q[W_SCR_STATE-W_DATA-1:0], scr_rev};
   end

   assign prbs_en = i_clk_en && (mode_eff == MODE_PRBS31);

   eth_pcs_prbs31_gen u_prbs31 (
      .clk_i  (i_clk),
      .rst_i  (i_reset),
      .en_i   (prbs_en),
      .word_o (prbs_w)
   );

   always_comb begin
      case (mode_eff)
         MODE_BYPASS: o_scr_data = i_data;
         MODE_PRBS31: o_scr_data = prbs_w;
         default:     o_scr_data = scr_w;
      endcase
   end

   assign o_sync_data   = i_sync_data;
   assign o_mode_active = mode_eff;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s_q    <= SCR_SEED;
         mode_q <= MODE_NORMAL;
      end else begin
         s_q    <= s_d;
         mode_q <= mode_d;
      end
   end

endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// ----------------------------------------------------------------------------
// tb_eth_pcs_tx_scrambler
// Directed and random stimulus against bit-serial scrambler / PRBS31
// reference models, plus hand-computed vectors for the first words.
// ----------------------------------------------------------------------------
module tb_eth_pcs_tx_scrambler;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_clk_en;
   logic [0:0]  i_trans_cnt;
   logic [1:0]  i_mode;
   logic [1:0]  i_sync_data;
   logic [31:0] i_data;
   logic [1:0]  o_sync_data;
   logic [31:0] o_scr_data;
   logic [1:0]  o_mode_active;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   string       phase    = "init";

   // Reference model state
   logic [57:0] m_s;
   logic [30:0] m_p;
   logic        tc;
   logic [1:0]  am_q;

   always #5 clk = ~clk;

   eth_pcs_tx_scrambler dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_clk_en      (i_clk_en),
      .i_trans_cnt   (i_trans_cnt),
      .i_mode        (i_mode),
      .i_sync_data   (i_sync_data),
      .i_data        (i_data),
      .o_sync_data   (o_sync_data),
      .o_scr_data    (o_scr_data),
      .o_mode_active (o_mode_active)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
      end
   endtask

   // Bit-serial scrambler: out = in ^ s[38] ^ s[57], then shift out in.
   task automatic model_scr(input logic [31:0] d, input logic adv, output logic [31:0] q);
      logic [57:0] s;
      s = m_s;
      for (int i = 0; i < 32; i++) begin
         q[i] = d[i] ^ s[38] ^ s[57];
         s    = {s[56:0], q[i]};
      end
      if (adv) m_s = s;
   endtask

   // Bit-serial PRBS31: h[0] newest; b = b[n-31] ^ b[n-28].
   task automatic model_prbs(input logic adv, output logic [31:0] q);
      logic [30:0] h;
      logic        b;
      h = m_p;
      for (int i = 0; i < 32; i++) begin
         b    = h[30] ^ h[27];
         q[i] = b;
         h    = {h[29:0], b};
      end
      if (adv) m_p = h;
   endtask

   function automatic logic [1:0] model_mode(input logic [1:0] m);
      return (m == 2'd3) ? 2'd0 : m;
   endfunction

   // One transfer: drive inputs after the rising edge, check at the falling
   // edge, then advance the model's block position and applied mode.
   task automatic step(input logic en, input logic [1:0] mode, input logic [31:0] data,
                       output logic [31:0] obs);
      logic [1:0]  am;
      logic [1:0]  sync;
      logic [31:0] exp_d;
      logic [31:0] dummy;
      sync        = 2'($urandom_range(0, 3));
      i_clk_en    = en;
      i_mode      = mode;
      i_data      = data;
      i_trans_cnt = tc;
      i_sync_data = sync;
      am = (en && (tc == 1'b0)) ? model_mode(mode) : am_q;
      case (am)
         2'd1: begin
            exp_d = data;
            model_scr(data, en, dummy);
         end
         2'd2:    model_prbs(en, exp_d);
         default: model_scr(data, en, exp_d);
      endcase
      @(negedge clk);
      obs = o_scr_data;
      check_eq("data", o_scr_data, exp_d);
      check_eq("mode", 32'(o_mode_active), 32'(am));
      check_eq("sync", 32'(o_sync_data), 32'(sync));
      @(posedge clk);
      #1;
      if (en) begin
         tc   = ~tc;
         am_q = am;
      end
   endtask

   task automatic model_seed();
      m_s  = '1;
      m_p  = '1;
      tc   = 1'b0;
      am_q = 2'd0;
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      i_clk_en = 1'b0;
      i_data   = '0;
      #2;
      i_reset = 1'b1;
      #1;
      check_eq("rst_mode", 32'(o_mode_active), 32'd0);
      check_eq("rst_data", o_scr_data, 32'h0000_0000);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      model_seed();
   endtask

   initial begin
      logic [31:0] obs;
      logic [31:0] d;
      logic        en;

      i_reset = 1'b1; i_clk_en = 1'b0; i_mode = 2'd0;
      i_data = '0; i_sync_data = '0; i_trans_cnt = '0;
      model_seed();
      #3;
      phase = "reset";
      check_eq("rst_mode", 32'(o_mode_active), 32'd0);
      check_eq("rst_data", o_scr_data, 32'h0000_0000);
      @(posedge clk);
      #1;
      i_reset = 1'b0;

      phase = "normal_zero";
      step(1'b1, 2'd0, 32'h0, obs);
      check_eq("hand_w0", obs, 32'h0000_0000);
      step(1'b1, 2'd0, 32'h0, obs);
      check_eq("hand_w1", obs, 32'h03FF_FF80);

      phase = "normal_rand";
      for (int n = 0; n < 1000; n++) step(1'b1, 2'd0, $urandom, obs);

      phase = "gearbox_en";
      for (int c = 0; c < 600; c++) begin
         en = (c % 33 != 32) && ($urandom_range(0, 3) != 0);
         step(en, 2'd0, $urandom, obs);
      end

      phase = "bypass";
      if (tc) step(1'b1, 2'd0, $urandom, obs);
      for (int n = 0; n < 10; n++) begin
         d = $urandom;
         step(1'b1, 2'd1, d, obs);
         check_eq("bypass_eq_data", obs, d);
      end
      phase = "bypass_to_normal";
      for (int n = 0; n < 20; n++) step(1'b1, 2'd0, $urandom, obs);

      phase = "defer";
      if (tc) step(1'b1, 2'd0, $urandom, obs);
      step(1'b1, 2'd0, $urandom, obs);
      step(1'b1, 2'd2, $urandom, obs);          // trans_cnt = 1: deferred
      check_eq("defer_tc1", 32'(o_mode_active), 32'd0);
      step(1'b0, 2'd2, $urandom, obs);          // disabled: still deferred
      phase = "prbs31";
      step(1'b1, 2'd2, $urandom, obs);
      check_eq("prbs_first", obs, 32'h7000_0000);
      for (int n = 0; n < 8192; n++) step(1'b1, 2'd2, $urandom, obs);
      for (int c = 0; c < 200; c++) step(($urandom_range(0, 3) != 0), 2'd2, $urandom, obs);

      phase = "reserved";
      for (int n = 0; n < 6; n++) step(1'b1, 2'd3, $urandom, obs);

      phase = "midblock_reset";
      if (tc) step(1'b1, 2'd1, $urandom, obs);
      step(1'b1, 2'd1, $urandom, obs);          // bypass applied, now mid-block
      do_reset();
      step(1'b1, 2'd0, 32'h0, obs);
      check_eq("seed_w0", obs, 32'h0000_0000);
      step(1'b1, 2'd0, 32'h0, obs);
      check_eq("seed_w1", obs, 32'h03FF_FF80);
      for (int n = 0; n < 50; n++) step(1'b1, 2'd0, $urandom, obs);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
